// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: state encodings and default sizing for the data-memory arbiter.
package dmem_arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_RESP = 1'b1} arbState_t;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W_DEF = 3;
endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// dmem_arb_wait_cnt: saturating count of cycles the EXT port has waited for a grant.
module dmem_arb_wait_cnt #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  assign sat = cnt == CNT_W'(LIMIT);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and the EXT loader port.
// Define DMEM_ARB_STARVE_GUARD_EN to force an EXT grant after STARVE_LIMIT waiting cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arbState_t state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic waitSat, forceGnt;

  dmem_arb_wait_cnt #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) waitCntInst (
    .clk(clk),
    .rst(rst),
    .inc(ext_req & ~ext_gnt),
    .clr(ext_gnt | ~ext_req),
    .cnt(waitCnt),
    .sat(waitSat)
  );

`ifdef DMEM_ARB_STARVE_GUARD_EN
  assign forceGnt = waitSat;
`else
  assign forceGnt = waitSat & 1'b0;
`endif

  always_comb begin
    ext_gnt   = 1'b0;
    cpu_stall = 1'b0;
    nextState = ARB_IDLE;
    ext_gnt   = ~rst & (state == ARB_IDLE) & ext_req & (~cpu_req | forceGnt);
    cpu_stall = ext_gnt & cpu_req;
    mem_we    = ~rst & (ext_gnt ? ext_we : cpu_req & cpu_we);
    mem_addr  = ext_gnt ? ext_addr : cpu_addr;
    mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;
    nextState = (ext_gnt & ~ext_we) ? ARB_RESP : ARB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ext_rdata <= '0;
    end else begin
      state <= nextState;
      if (ext_gnt && !ext_we) ext_rdata <= mem_rdata;
    end
  end

  // a reset landing in RESP suppresses the response pulse
  assign ext_valid = (state == ARB_RESP) & ~rst;
  assign cpu_rdata = mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors, corner sequences and a randomized model check of dmem_arbiter.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cpu_req, cpu_we, cpu_stall, ext_req, ext_we, ext_gnt, ext_valid, mem_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ext_addr, ext_wdata, ext_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] ram [256];

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_valid(ext_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                       input logic [7:0] cd, input logic er, input logic ew,
                       input logic [7:0] ea, input logic [7:0] ed);
    @(negedge clk);
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    #1;
  endtask

  typedef struct {
    logic r, cr, cw;
    logic [7:0] ca, cd;
    logic er, ew;
    logic [7:0] ea, ed;
    logic gnt, stall, we, valid;
    logic [7:0] erd;
    logic chkCpu;
    logic [7:0] crd;
  } vec_t;
  vec_t vt [8];

  bit pend;
  logic [7:0] rdReg;
  int cnt;
  logic [7:0] shadow [256];

  initial begin
    int gnts, stalls;
    logic [7:0] keep50;
    // write 0x10, read it back from both ports, then a refused EXT write under CPU traffic
    vt[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5};
    vt[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
    vt[5] = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h5C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
    vt[6] = '{1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h5C};
    vt[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00};

    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].r, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].er, vt[i].ew, vt[i].ea, vt[i].ed);
      chk($sformatf("vec%0d ext_gnt", i), int'(ext_gnt), int'(vt[i].gnt));
      chk($sformatf("vec%0d cpu_stall", i), int'(cpu_stall), int'(vt[i].stall));
      chk($sformatf("vec%0d mem_we", i), int'(mem_we), int'(vt[i].we));
      chk($sformatf("vec%0d ext_valid", i), int'(ext_valid), int'(vt[i].valid));
      chk($sformatf("vec%0d ext_rdata", i), int'(ext_rdata), int'(vt[i].erd));
      if (vt[i].chkCpu) chk($sformatf("vec%0d cpu_rdata", i), int'(cpu_rdata), int'(vt[i].crd));
    end

    // CPU busy every cycle while EXT keeps asking
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h41, 8'h99);
      chk($sformatf("starve c%0d ext_gnt", c), int'(ext_gnt), int'(GUARD && (c % 5 == 4)));
      chk($sformatf("starve c%0d cpu_stall", c), int'(cpu_stall), int'(GUARD && (c % 5 == 4)));
    end

    // same-address collision: CPU write must be the final value
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    gnts = 0;
    stalls = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h22, gnts == 0, 1'b1, 8'h20, 8'h11);
      if (ext_gnt) chk("collide mem_wdata", int'(mem_wdata), 'h11);
      gnts += int'(ext_gnt);
      stalls += int'(cpu_stall);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("collide stalls", stalls, int'(GUARD));
    chk("collide ram20", int'(ram[8'h20]), 'h22);

    // reset while a read response is pending
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("rstresp grant", int'(ext_gnt), 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("rstresp valid0", int'(ext_valid), 0);
    chk("rstresp gnt0", int'(ext_gnt), 0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rstresp valid1", int'(ext_valid), 0);
    chk("rstresp rdata", int'(ext_rdata), 0);
    chk("rstresp waitCnt", int'(dut.waitCnt), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("rstresp idle regrant", int'(ext_gnt), 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rstresp readback", int'(ext_rdata), 'hA5);

    // abort: EXT gives up before being granted
    keep50 = ram[8'h50];
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h50, 8'hEE);
      chk("abort mem_we", int'(mem_we), 0);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("abort mem_we drop", int'(mem_we), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("abort waitCnt", int'(dut.waitCnt), 0);
    chk("abort ram50", int'(ram[8'h50]), int'(keep50));

    // randomized traffic against the reference model
    begin
      bit eHold, r, cr, cw, ew, eg, es, ewe, ev;
      logic [7:0] ca, cd, ea, ed, ead, ewd;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 256; i++) shadow[i] = ram[i];
      pend = 1'b0;
      rdReg = 8'h00;
      cnt = 0;
      eHold = 1'b0;
      ew = 1'b0;
      ea = 8'h00;
      ed = 8'h00;
      for (int k = 0; k < 600; k++) begin
        r = $urandom_range(0, 49) == 0;
        cr = $urandom_range(0, 9) < 7;
        cw = 1'($urandom);
        ca = 8'($urandom_range(0, 15));
        cd = 8'($urandom);
        if (!eHold) begin
          if ($urandom_range(0, 2) == 0) begin
            eHold = 1'b1;
            ew = 1'($urandom);
            ea = 8'($urandom_range(0, 15));
            ed = 8'($urandom);
          end
        end else if ($urandom_range(0, 11) == 0) eHold = 1'b0;
        drive(r, cr, cw, ca, cd, eHold, ew, ea, ed);
        eg = !r && !pend && eHold && (!cr || (GUARD && cnt == LIMIT));
        es = eg && cr;
        ewe = !r && (eg ? ew : (cr && cw));
        ead = eg ? ea : ca;
        ewd = eg ? ed : cd;
        ev = pend && !r;
        chk("rnd ext_gnt", int'(ext_gnt), int'(eg));
        chk("rnd cpu_stall", int'(cpu_stall), int'(es));
        chk("rnd mem_we", int'(mem_we), int'(ewe));
        chk("rnd ext_valid", int'(ext_valid), int'(ev));
        chk("rnd ext_rdata", int'(ext_rdata), int'(rdReg));
        chk("rnd waitCnt", int'(dut.waitCnt), cnt);
        if (!r) chk("rnd mem_addr", int'(mem_addr), int'(ead));
        if (ewe) chk("rnd mem_wdata", int'(mem_wdata), int'(ewd));
        if (!r && cr && !es) chk("rnd cpu_rdata", int'(cpu_rdata), int'(shadow[ca]));
        if (r) begin
          pend = 1'b0;
          rdReg = 8'h00;
          cnt = 0;
        end else begin
          if (eg && !ew) rdReg = shadow[ea];
          if (ewe) shadow[ead] = ewd;
          pend = eg && !ew;
          cnt = (!eHold || eg) ? 0 : (cnt < LIMIT ? cnt + 1 : cnt);
          if (eg) eHold = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
